// File: rtl/riscv_branch_pkg.sv
// ----------------------------------------------------------------------------
// riscv_branch_pkg
//   Shared encodings for branch/jump resolution, also used by the decoder.
//   - F3_* : RISC-V conditional-branch funct3 values
//   - br_op_e : resolution operation class carried on in_op
// ----------------------------------------------------------------------------
package riscv_branch_pkg;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [1:0] {
      OP_BR   = 2'b00,
      OP_JAL  = 2'b01,
      OP_JALR = 2'b10,
      OP_RSV  = 2'b11
   } br_op_e;

endpackage

// File: rtl/branch_cond.sv
// ----------------------------------------------------------------------------
// branch_cond
//   Combinational evaluation of a RISC-V conditional branch.
//   Ports:
//     a_i, b_i   in  XLEN  operands (rs1, rs2)
//     funct3_i   in  3     branch condition encoding
//     taken_o    out 1     condition holds
//     illegal_o  out 1     funct3 is not a branch condition (010/011)
// ----------------------------------------------------------------------------
module branch_cond
   import riscv_branch_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  logic [2:0]      funct3_i,
   output logic            taken_o,
   output logic            illegal_o
);

   always_comb begin
      taken_o   = 1'b0;
      illegal_o = 1'b0;
      case (funct3_i)
         F3_BEQ:  taken_o = (a_i == b_i);
         F3_BNE:  taken_o = (a_i != b_i);
         F3_BLT:  taken_o = ($signed(a_i) <  $signed(b_i));
         F3_BGE:  taken_o = ($signed(a_i) >= $signed(b_i));
         F3_BLTU: taken_o = (a_i <  b_i);
         F3_BGEU: taken_o = (a_i >= b_i);
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// ----------------------------------------------------------------------------
// branch_resolve_unit
//   Resolves conditional branches, JAL and JALR: computes the actual next PC,
//   the link value (pc+4) and whether the fetch prediction was wrong. The
//   result is held in a single output register behind a valid/ready handshake.
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     flush                      kill the held result; blocks accept this cycle
//     in_valid/in_ready          request handshake
//     in_op, in_funct3           operation class and branch condition
//     in_pc, in_rs1, in_rs2, in_imm   PC, operands, sign-extended immediate
//     in_pred_taken, in_pred_target   fetch-stage prediction
//     out_valid/out_ready        result handshake
//     out_taken, out_next_pc, out_link, out_mispredict,
//     out_misaligned, out_illegal     registered resolution result
//     cnt_clear                  synchronous clear of both counters
//     cnt_branches, cnt_mispredicts   saturating counters of retired results
// ----------------------------------------------------------------------------
module branch_resolve_unit
   import riscv_branch_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int CNT_W  = 16,
   parameter int IALIGN = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [2:0]       in_funct3,
   input  logic [XLEN-1:0]  in_pc,
   input  logic [XLEN-1:0]  in_rs1,
   input  logic [XLEN-1:0]  in_rs2,
   input  logic [XLEN-1:0]  in_imm,
   input  logic             in_pred_taken,
   input  logic [XLEN-1:0]  in_pred_target,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_taken,
   output logic [XLEN-1:0]  out_next_pc,
   output logic [XLEN-1:0]  out_link,
   output logic             out_mispredict,
   output logic             out_misaligned,
   output logic             out_illegal,
   input  logic             cnt_clear,
   output logic [CNT_W-1:0] cnt_branches,
   output logic [CNT_W-1:0] cnt_mispredicts
);

   br_op_e            op;
   logic              cond_taken;
   logic              cond_illegal;
   logic [XLEN-1:0]   pc_plus4;
   logic [XLEN-1:0]   rel_target;
   logic [XLEN-1:0]   jalr_target;
   logic [XLEN-1:0]   target;
   logic [XLEN-1:0]   next_pc;
   logic [XLEN-1:0]   pred_next_pc;
   logic              res_taken;
   logic              res_illegal;
   logic              res_mispredict;
   logic              res_misaligned;
   logic              target_unaligned;
   logic              accept;
   logic              retire;

   logic              valid_q, valid_d;
   logic              taken_q;
   logic [XLEN-1:0]   next_pc_q;
   logic [XLEN-1:0]   link_q;
   logic              mispredict_q;
   logic              misaligned_q;
   logic              illegal_q;
   logic              is_br_q;
   logic [CNT_W-1:0]  cnt_br_q, cnt_br_d;
   logic [CNT_W-1:0]  cnt_mp_q, cnt_mp_d;

   assign op = br_op_e'(in_op);

   branch_cond #(.XLEN(XLEN)) u_cond (
      .a_i       (in_rs1),
      .b_i       (in_rs2),
      .funct3_i  (in_funct3),
      .taken_o   (cond_taken),
      .illegal_o (cond_illegal)
   );

   assign pc_plus4    = in_pc + XLEN'(4);
   assign rel_target  = in_pc + in_imm;
   // JALR clears bit 0 of the computed address.
   assign jalr_target = (in_rs1 + in_imm) & {{(XLEN-1){1'b1}}, 1'b0};

   always_comb begin
      res_taken   = 1'b0;
      res_illegal = 1'b0;
      target      = rel_target;
      case (op)
         OP_BR: begin
            res_taken   = cond_taken & ~cond_illegal;
            res_illegal = cond_illegal;
         end
         OP_JAL:  res_taken = 1'b1;
         OP_JALR: begin
            res_taken = 1'b1;
            target    = jalr_target;
         end
         default: res_illegal = 1'b1;
      endcase
   end

   // With compressed instructions (16-bit alignment) no target can be misaligned.
   generate
      if (IALIGN == 32) begin : g_align32
         assign target_unaligned = target[1];
      end else begin : g_align16
         assign target_unaligned = 1'b0;
      end
   endgenerate

   assign next_pc        = res_taken ? target : pc_plus4;
   assign pred_next_pc   = in_pred_taken ? in_pred_target : pc_plus4;
   // Illegal instructions trap instead of redirecting, so they never mispredict.
   assign res_mispredict = ~res_illegal & (next_pc != pred_next_pc);
   assign res_misaligned = res_taken & target_unaligned;

   assign in_ready = ~flush & (~valid_q | out_ready);
   assign accept   = in_valid & in_ready;
   assign retire   = valid_q & out_ready & ~flush;

   always_comb begin
      valid_d = valid_q;
      if (flush)
         valid_d = 1'b0;
      else if (accept)
         valid_d = 1'b1;
      else if (out_ready)
         valid_d = 1'b0;
   end

   always_comb begin
      cnt_br_d = cnt_br_q;
      cnt_mp_d = cnt_mp_q;
      if (cnt_clear) begin
         cnt_br_d = '0;
         cnt_mp_d = '0;
      end else if (retire) begin
         if (is_br_q && (cnt_br_q != '1))
            cnt_br_d = cnt_br_q + CNT_W'(1);
         if (mispredict_q && (cnt_mp_q != '1))
            cnt_mp_d = cnt_mp_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q      <= 1'b0;
         taken_q      <= 1'b0;
         next_pc_q    <= '0;
         link_q       <= '0;
         mispredict_q <= 1'b0;
         misaligned_q <= 1'b0;
         illegal_q    <= 1'b0;
         is_br_q      <= 1'b0;
         cnt_br_q     <= '0;
         cnt_mp_q     <= '0;
      end else begin
         valid_q  <= valid_d;
         cnt_br_q <= cnt_br_d;
         cnt_mp_q <= cnt_mp_d;
         if (accept) begin
            taken_q      <= res_taken;
            next_pc_q    <= next_pc;
            link_q       <= pc_plus4;
            mispredict_q <= res_mispredict;
            misaligned_q <= res_misaligned;
            illegal_q    <= res_illegal;
            is_br_q      <= (op == OP_BR) & ~res_illegal;
         end
      end
   end

   assign out_valid       = valid_q;
   assign out_taken       = taken_q;
   assign out_next_pc     = next_pc_q;
   assign out_link        = link_q;
   assign out_mispredict  = mispredict_q;
   assign out_misaligned  = misaligned_q;
   assign out_illegal     = illegal_q;
   assign cnt_branches    = cnt_br_q;
   assign cnt_mispredicts = cnt_mp_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ----------------------------------------------------------------------------
// tb_branch_resolve_unit
//   Directed and randomized checks of branch_resolve_unit (XLEN=32, CNT_W=4,
//   IALIGN=32) against a transaction-level reference model.
// ----------------------------------------------------------------------------
module tb_branch_resolve_unit;

   localparam int XLEN    = 32;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [1:0]       in_op = '0;
   logic [2:0]       in_funct3 = '0;
   logic [XLEN-1:0]  in_pc = '0, in_rs1 = '0, in_rs2 = '0, in_imm = '0;
   logic             in_pred_taken = 1'b0;
   logic [XLEN-1:0]  in_pred_target = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic             out_taken;
   logic [XLEN-1:0]  out_next_pc, out_link;
   logic             out_mispredict, out_misaligned, out_illegal;
   logic             cnt_clear = 1'b0;
   logic [CNT_W-1:0] cnt_branches, cnt_mispredicts;

   branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W), .IALIGN(32)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_funct3(in_funct3), .in_pc(in_pc),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_taken(out_taken), .out_next_pc(out_next_pc), .out_link(out_link),
      .out_mispredict(out_mispredict), .out_misaligned(out_misaligned),
      .out_illegal(out_illegal), .cnt_clear(cnt_clear),
      .cnt_branches(cnt_branches), .cnt_mispredicts(cnt_mispredicts)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  op;
      logic [2:0]  f3;
      logic [31:0] pc, rs1, rs2, imm;
      logic        ptaken;
      logic [31:0] ptgt;
   } req_t;

   typedef struct packed {
      logic        taken;
      logic [31:0] npc;
      logic [31:0] link;
      logic        mp;
      logic        mis;
      logic        ill;
   } res_t;

   int   n_tests = 0;
   int   n_fail  = 0;

   // reference model state
   bit   m_valid = 0;
   res_t m_res   = '0;
   bit   m_isbr  = 0;
   int   m_cb    = 0;
   int   m_cm    = 0;

   // currently driven stimulus
   req_t cur = '0;
   bit   cur_v = 0, cur_ordy = 0, cur_fl = 0, cur_clr = 0;

   localparam req_t IDLE = '0;

   function automatic res_t model(req_t r);
      res_t        e;
      logic [31:0] tgt;
      logic [31:0] pred;
      e       = '0;
      e.link  = r.pc + 32'd4;
      tgt     = r.pc + r.imm;
      if (r.op == 2'd0) begin
         case (r.f3)
            3'd0: e.taken = (r.rs1 == r.rs2);
            3'd1: e.taken = (r.rs1 != r.rs2);
            3'd4: e.taken = ($signed(r.rs1) <  $signed(r.rs2));
            3'd5: e.taken = ($signed(r.rs1) >= $signed(r.rs2));
            3'd6: e.taken = (r.rs1 <  r.rs2);
            3'd7: e.taken = (r.rs1 >= r.rs2);
            default: e.ill = 1'b1;
         endcase
      end else if (r.op == 2'd1) begin
         e.taken = 1'b1;
      end else if (r.op == 2'd2) begin
         e.taken = 1'b1;
         tgt     = (r.rs1 + r.imm) & 32'hFFFF_FFFE;
      end else begin
         e.ill = 1'b1;
      end
      e.npc = e.taken ? tgt : r.pc + 32'd4;
      pred  = r.ptaken ? r.ptgt : r.pc + 32'd4;
      e.mp  = !e.ill && (e.npc != pred);
      e.mis = e.taken && tgt[1];
      return e;
   endfunction

   function automatic bit model_is_br(req_t r);
      return (r.op == 2'd0) && (r.f3 != 3'd2) && (r.f3 != 3'd3);
   endfunction

   function automatic bit model_ready();
      return !cur_fl && (!m_valid || cur_ordy);
   endfunction

   function automatic res_t dut_res();
      return {out_taken, out_next_pc, out_link, out_mispredict, out_misaligned, out_illegal};
   endfunction

   task automatic drive(req_t r, bit v, bit ordy, bit fl, bit clr);
      cur = r; cur_v = v; cur_ordy = ordy; cur_fl = fl; cur_clr = clr;
      in_op = r.op; in_funct3 = r.f3; in_pc = r.pc; in_rs1 = r.rs1;
      in_rs2 = r.rs2; in_imm = r.imm; in_pred_taken = r.ptaken;
      in_pred_target = r.ptgt;
      in_valid = v; out_ready = ordy; flush = fl; cnt_clear = clr;
      #1;
   endtask

   // Advance the model by one clock using the currently driven inputs, then
   // step the DUT through the same edge.
   task automatic tick();
      bit acc, hs;
      acc = cur_v && model_ready();
      hs  = m_valid && cur_ordy && !cur_fl;
      if (cur_clr) begin
         m_cb = 0; m_cm = 0;
      end else if (hs) begin
         if (m_isbr && m_cb < CNT_MAX) m_cb++;
         if (m_res.mp && m_cm < CNT_MAX) m_cm++;
      end
      if (cur_fl)          m_valid = 0;
      else if (acc)        m_valid = 1;
      else if (cur_ordy)   m_valid = 0;
      if (acc) begin
         m_res  = model(cur);
         m_isbr = model_is_br(cur);
         $display("[TB] accept op=%0d f3=%0d pc=%h -> taken=%0b npc=%h mp=%0b mis=%0b ill=%0b",
                  cur.op, cur.f3, cur.pc, m_res.taken, m_res.npc, m_res.mp, m_res.mis, m_res.ill);
      end
      @(posedge clk);
      #1;
   endtask

   function automatic req_t mk(logic [1:0] op, logic [2:0] f3, logic [31:0] pc,
                               logic [31:0] rs1, logic [31:0] rs2, logic [31:0] imm,
                               logic pt, logic [31:0] ptgt);
      req_t r;
      r.op = op; r.f3 = f3; r.pc = pc; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm;
      r.ptaken = pt; r.ptgt = ptgt;
      return r;
   endfunction

   task automatic test_reset();
      drive(IDLE, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if (out_valid !== 1'b0 || dut_res() !== res_t'(0)) begin
         n_fail++;
         $display("FAIL reset_outputs: valid=%0b res=%h required valid=0 res=0", out_valid, dut_res());
      end
      n_tests++;
      if (cnt_branches !== '0 || cnt_mispredicts !== '0) begin
         n_fail++;
         $display("FAIL reset_counters: br=%0d mp=%0d required 0 0", cnt_branches, cnt_mispredicts);
      end
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_in_ready: got %0b required 1", in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_directed();
      req_t r;
      drive(IDLE, 0, 1, 0, 1); tick();
      // BLT signed: -1 < 1
      r = mk(2'd0, 3'd4, 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20, 1'b0, 32'h0);
      drive(r, 1, 1, 0, 0); tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_taken !== 1'b1 || out_next_pc !== 32'h120 || out_mispredict !== 1'b1) begin
         n_fail++;
         $display("FAIL blt: valid=%0b taken=%0b npc=%h mp=%0b required 1 1 00000120 1",
                  out_valid, out_taken, out_next_pc, out_mispredict);
      end
      // BLTU unsigned: 0xFFFFFFFF not < 1
      r = mk(2'd0, 3'd6, 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20, 1'b0, 32'h0);
      drive(r, 1, 1, 0, 0); tick();
      n_tests++;
      if (out_taken !== 1'b0 || out_next_pc !== 32'h104 || out_mispredict !== 1'b0) begin
         n_fail++;
         $display("FAIL bltu: taken=%0b npc=%h mp=%0b required 0 00000104 0",
                  out_taken, out_next_pc, out_mispredict);
      end
      drive(IDLE, 0, 1, 0, 0); tick();
      n_tests++;
      if (cnt_branches !== 4'd2 || cnt_mispredicts !== 4'd1) begin
         n_fail++;
         $display("FAIL branch_counts: br=%0d mp=%0d required 2 1", cnt_branches, cnt_mispredicts);
      end
      // JALR with misaligned target, correctly predicted
      r = mk(2'd2, 3'd0, 32'h200, 32'h1003, 32'h0, 32'h0, 1'b1, 32'h1002);
      drive(r, 1, 1, 0, 0); tick();
      n_tests++;
      if (out_next_pc !== 32'h1002 || out_link !== 32'h204 || out_misaligned !== 1'b1 ||
          out_mispredict !== 1'b0 || out_taken !== 1'b1) begin
         n_fail++;
         $display("FAIL jalr: npc=%h link=%h mis=%0b mp=%0b taken=%0b required 00001002 00000204 1 0 1",
                  out_next_pc, out_link, out_misaligned, out_mispredict, out_taken);
      end
      n_tests++;
      if (dut_res() !== m_res) begin
         n_fail++;
         $display("FAIL jalr_model: got %h required %h", dut_res(), m_res);
      end
      drive(IDLE, 0, 1, 0, 0); tick();
   endtask

   task automatic test_illegal();
      req_t r;
      r = mk(2'd0, 3'd2, 32'h300, 32'h5, 32'h5, 32'h40, 1'b1, 32'h340);
      drive(r, 1, 1, 0, 0); tick();
      n_tests++;
      if (out_illegal !== 1'b1 || out_taken !== 1'b0 || out_mispredict !== 1'b0 || out_misaligned !== 1'b0) begin
         n_fail++;
         $display("FAIL illegal_f3: ill=%0b taken=%0b mp=%0b mis=%0b required 1 0 0 0",
                  out_illegal, out_taken, out_mispredict, out_misaligned);
      end
      r = mk(2'd3, 3'd0, 32'h400, 32'h0, 32'h0, 32'h2, 1'b1, 32'h402);
      drive(r, 1, 1, 0, 0); tick();
      n_tests++;
      if (out_illegal !== 1'b1 || out_taken !== 1'b0 || out_next_pc !== 32'h404) begin
         n_fail++;
         $display("FAIL illegal_op: ill=%0b taken=%0b npc=%h required 1 0 00000404",
                  out_illegal, out_taken, out_next_pc);
      end
      drive(IDLE, 0, 1, 0, 0); tick();
      n_tests++;
      if (cnt_branches !== m_cb[CNT_W-1:0] || cnt_mispredicts !== m_cm[CNT_W-1:0]) begin
         n_fail++;
         $display("FAIL illegal_counts: br=%0d mp=%0d required %0d %0d",
                  cnt_branches, cnt_mispredicts, m_cb, m_cm);
      end
   endtask

   task automatic test_backpressure();
      req_t a, b;
      res_t held;
      a = mk(2'd1, 3'd0, 32'h500, 32'h0, 32'h0, 32'h80, 1'b1, 32'h580);
      b = mk(2'd0, 3'd0, 32'h600, 32'h7, 32'h7, 32'h10, 1'b0, 32'h0);
      drive(a, 1, 0, 0, 0); tick();
      held = m_res;
      for (int i = 0; i < 3; i++) begin
         drive(b, 1, 0, 0, 0);
         n_tests++;
         if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_in_ready[%0d]: got %0b required 0", i, in_ready);
         end
         tick();
         n_tests++;
         if (out_valid !== 1'b1 || dut_res() !== held) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: valid=%0b res=%h required 1 %h", i, out_valid, dut_res(), held);
         end
      end
      drive(b, 1, 1, 0, 0);
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL release_in_ready: got %0b required 1", in_ready);
      end
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || dut_res() !== m_res || out_next_pc !== 32'h610) begin
         n_fail++;
         $display("FAIL release_next: valid=%0b res=%h required 1 %h", out_valid, dut_res(), m_res);
      end
      drive(IDLE, 0, 1, 0, 0); tick();
   endtask

   task automatic test_back_to_back();
      req_t r;
      drive(IDLE, 0, 1, 0, 1); tick();
      for (int i = 0; i < 20; i++) begin
         r = mk(2'd1, 3'd0, 32'h1000 + 32'(i * 4), 32'h0, 32'h0, 32'h100, 1'b0, 32'h0);
         drive(r, 1, 1, 0, 0);
         n_tests++;
         if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_in_ready[%0d]: got %0b required 1", i, in_ready);
         end
         tick();
      end
      drive(IDLE, 0, 1, 0, 0); tick();
      n_tests++;
      if (cnt_mispredicts !== 4'hF || cnt_branches !== 4'h0) begin
         n_fail++;
         $display("FAIL saturate: mp=%0d br=%0d required 15 0", cnt_mispredicts, cnt_branches);
      end
   endtask

   task automatic test_flush_clear();
      req_t r;
      drive(IDLE, 0, 1, 0, 1); tick();
      r = mk(2'd0, 3'd1, 32'h700, 32'h1, 32'h2, 32'h40, 1'b0, 32'h0);
      drive(r, 1, 0, 0, 0); tick();
      // flush coincides with the consumer taking the result
      drive(r, 1, 1, 1, 0);
      n_tests++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_in_ready: got %0b required 0", in_ready);
      end
      tick();
      n_tests++;
      if (out_valid !== 1'b0 || cnt_branches !== 4'd0 || cnt_mispredicts !== 4'd0) begin
         n_fail++;
         $display("FAIL flush_drop: valid=%0b br=%0d mp=%0d required 0 0 0",
                  out_valid, cnt_branches, cnt_mispredicts);
      end
      // clear wins over a simultaneous retire
      drive(r, 1, 1, 0, 0); tick();
      drive(IDLE, 0, 1, 0, 1); tick();
      n_tests++;
      if (cnt_branches !== 4'd0 || cnt_mispredicts !== 4'd0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_wins: br=%0d mp=%0d valid=%0b required 0 0 0",
                  cnt_branches, cnt_mispredicts, out_valid);
      end
   endtask

   task automatic test_random();
      req_t r;
      int   k;
      logic [31:0] t;
      for (int i = 0; i < 300; i++) begin
         k = $urandom_range(0, 9);
         r.op  = (k < 6) ? 2'd0 : (k < 8) ? 2'd1 : (k < 9) ? 2'd2 : 2'd3;
         r.f3  = 3'($urandom_range(0, 7));
         t     = $urandom;
         r.pc  = t & 32'hFFFF_FFFC;
         r.rs1 = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
         r.rs2 = ($urandom_range(0, 2) == 0) ? r.rs1 : $urandom;
         t     = 32'($urandom_range(0, 8191)) - 32'd4096;
         r.imm = ($urandom_range(0, 3) == 0) ? t : (t & 32'hFFFF_FFFC);
         r.ptaken = 1'($urandom_range(0, 1));
         r.ptgt   = '0;
         r.ptgt   = ($urandom_range(0, 1) == 1) ? model(r).npc : $urandom;
         drive(r, ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7),
               ($urandom_range(0, 19) == 0), ($urandom_range(0, 29) == 0));
         n_tests++;
         if (in_ready !== model_ready()) begin
            n_fail++;
            $display("FAIL rand_in_ready[%0d]: got %0b required %0b", i, in_ready, model_ready());
         end
         tick();
         n_tests++;
         if (out_valid !== m_valid || (m_valid && dut_res() !== m_res)) begin
            n_fail++;
            $display("FAIL rand_out[%0d]: valid=%0b res=%h required %0b %h", i, out_valid, dut_res(), m_valid, m_res);
         end
         n_tests++;
         if (cnt_branches !== m_cb[CNT_W-1:0] || cnt_mispredicts !== m_cm[CNT_W-1:0]) begin
            n_fail++;
            $display("FAIL rand_cnt[%0d]: br=%0d mp=%0d required %0d %0d",
                     i, cnt_branches, cnt_mispredicts, m_cb, m_cm);
         end
      end
      drive(IDLE, 0, 1, 0, 0); tick();
   endtask

   task automatic test_async_reset();
      req_t r;
      r = mk(2'd1, 3'd0, 32'h800, 32'h0, 32'h0, 32'h8, 1'b0, 32'h0);
      drive(r, 1, 1, 0, 0); tick();
      drive(r, 1, 0, 0, 0); tick();
      #2;
      rst_n = 1'b0;
      #1;
      m_valid = 0; m_res = '0; m_cb = 0; m_cm = 0;
      n_tests++;
      if (out_valid !== 1'b0 || dut_res() !== res_t'(0) || cnt_branches !== '0 || cnt_mispredicts !== '0) begin
         n_fail++;
         $display("FAIL async_reset: valid=%0b res=%h br=%0d mp=%0d required all 0",
                  out_valid, dut_res(), cnt_branches, cnt_mispredicts);
      end
      drive(IDLE, 0, 1, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      n_tests++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_valid: got %0b required 0", out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_illegal();
      test_backpressure();
      test_back_to_back();
      test_flush_clear();
      test_random();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
